// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and helpers for the on-demand Galois LFSR random generator.
package lfsr_rand_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_e;

  // Maximal-length Galois masks for common widths
  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'hA300_0000;

  // Operates on zero-extended values so any WIDTH up to 32 can share it.
  function automatic logic [31:0] galois_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'd0);
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_galois.sv
// Galois LFSR register with seed load and all-zero recovery to SEED.
// lockup is registered: it is high the cycle after a zero seed was replaced.
module lfsr_galois_core
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  logic [WIDTH-1:0] state_d, state_q;
  logic             lockup_d, lockup_q;

  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    if (load) begin
      if (load_val == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = load_val;
      end
    end else if (shift_en) begin
      state_d = WIDTH'(galois_step(32'(state_q), 32'(TAPS)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign state  = state_q;
  assign lockup = lockup_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// On-demand random draws: each accepted req advances the LFSR SHIFTS times,
// then presents state[OUT_W-1:0] under a num_valid/num_ack handshake.
module lfsr_rand_gen
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'h0001,
  parameter int               OUT_W  = 8,
  parameter int               SHIFTS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             num_valid,
  output logic [OUT_W-1:0] num,
  input  logic             num_ack,
  output logic             lockup,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int CW = $clog2(SHIFTS + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH must be 4..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rand_gen: SEED must be non-zero");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rand_gen: OUT_W must be 1..WIDTH");
  end
  if (SHIFTS < 1) begin : g_bad_shifts
    $error("lfsr_rand_gen: SHIFTS must be at least 1");
  end

  fsm_state_e       fsm_d, fsm_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [OUT_W-1:0] num_d, num_q;
  logic             num_valid_d, num_valid_q;
  logic             ready_d, ready_q;
  logic             shift_en;

  lfsr_galois_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr_state),
    .lockup   (lockup)
  );

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    num_valid_d = num_valid_q;
    shift_en    = 1'b0;
    if (seed_load) begin
      // Reseed aborts any draw in flight; num keeps the last delivered value.
      fsm_d       = ST_IDLE;
      cnt_d       = '0;
      num_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (req) begin
            cnt_d = CW'(SHIFTS);
            fsm_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Capture the value the final shift produces, in the same edge.
            num_d       = OUT_W'(galois_step(32'(lfsr_state), 32'(TAPS)));
            num_valid_d = 1'b1;
            fsm_d       = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (num_ack) begin
            num_valid_d = 1'b0;
            fsm_d       = ST_IDLE;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
    ready_d = (fsm_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign num_valid = num_valid_q;
  assign num       = num_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench: default 16-bit generator plus a 4-bit, one-shift instance.
module tb_lfsr_rand_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, seed_load, req, num_ack;
  logic [15:0] seed_in;
  logic        ready, num_valid, lockup;
  logic [7:0]  num;
  logic [15:0] lfsr_state;

  logic        reset4, seed_load4, req4, ack4;
  logic [3:0]  seed_in4;
  logic        ready4, valid4, lockup4;
  logic [3:0]  num4, state4;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived 4-bit sequence from seed 1 with taps 0xC, one shift per draw
  logic [3:0] seq4 [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                            4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

  lfsr_rand_gen u_dut (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .req        (req),
    .ready      (ready),
    .num_valid  (num_valid),
    .num        (num),
    .num_ack    (num_ack),
    .lockup     (lockup),
    .lfsr_state (lfsr_state)
  );

  lfsr_rand_gen #(
    .WIDTH  (4),
    .TAPS   (4'hC),
    .SEED   (4'h1),
    .OUT_W  (4),
    .SHIFTS (1)
  ) u_dut4 (
    .clk        (clk),
    .reset      (reset4),
    .seed_load  (seed_load4),
    .seed_in    (seed_in4),
    .req        (req4),
    .ready      (ready4),
    .num_valid  (valid4),
    .num        (num4),
    .num_ack    (ack4),
    .lockup     (lockup4),
    .lfsr_state (state4)
  );

  // Pulse req for one edge, then count edges after acceptance until num_valid.
  task automatic do_req16(output int n);
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    n = 0;
    while (!num_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_ack16();
    @(negedge clk) num_ack = 1'b1;
    @(negedge clk) num_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (num_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", num_valid); end
    n_checks++; if (num !== 8'h00) begin n_fail++; $display("FAIL reset_num: got %h want 00", num); end
    n_checks++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL reset_lockup: got %b want 0", lockup); end
    n_checks++; if (lfsr_state !== 16'h0001) begin n_fail++; $display("FAIL reset_state: got %h want 0001", lfsr_state); end
    reset  = 1'b0;
    reset4 = 1'b0;
  endtask

  task automatic test_first_draw();
    int n;
    do_req16(n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL first_latency: got %0d want 8", n); end
    n_checks++; if (num !== 8'h68) begin n_fail++; $display("FAIL first_num: got %h want 68", num); end
    n_checks++; if (lfsr_state !== 16'h0168) begin n_fail++; $display("FAIL first_state: got %h want 0168", lfsr_state); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL first_ready_low: got %b want 0", ready); end
    do_ack16();
    n_checks++; if (ready !== 1'b1 || num_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_ack: ready=%b valid=%b want 1/0", ready, num_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_req16(n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d want 8", n); end
    n_checks++; if (num !== 8'h41) begin n_fail++; $display("FAIL b2b_num: got %h want 41", num); end
    n_checks++; if (lfsr_state !== 16'h7C41) begin n_fail++; $display("FAIL b2b_state: got %h want 7c41", lfsr_state); end
    do_ack16();
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk) begin seed_in = 16'h0001; seed_load = 1'b1; end
    @(negedge clk) seed_load = 1'b0;
    do_req16(n);
    n_checks++; if (n !== 8 || num !== 8'h68) begin
      n_fail++; $display("FAIL hold_draw: latency=%0d num=%h want 8/68", n, num);
    end
    for (int i = 0; i < 20; i++) begin
      req = (i == 5);
      @(negedge clk);
      n_checks++;
      if (num !== 8'h68 || num_valid !== 1'b1 || ready !== 1'b0 || lfsr_state !== 16'h0168) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: num=%h valid=%b ready=%b state=%h want 68/1/0/0168",
                 i, num, num_valid, ready, lfsr_state);
      end
    end
    req = 1'b0;
    do_ack16();
    repeat (2) @(negedge clk);
    n_checks++; if (ready !== 1'b1 || lfsr_state !== 16'h0168) begin
      n_fail++; $display("FAIL hold_req_not_queued: ready=%b state=%h want 1/0168", ready, lfsr_state);
    end
  endtask

  task automatic test_seed_abort();
    int n;
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    repeat (2) @(negedge clk);
    seed_in = 16'h0001; seed_load = 1'b1; req = 1'b1; num_ack = 1'b1;
    @(negedge clk) begin seed_load = 1'b0; req = 1'b0; num_ack = 1'b0; end
    n_checks++; if (ready !== 1'b1 || num_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: ready=%b valid=%b want 1/0", ready, num_valid);
    end
    n_checks++; if (lfsr_state !== 16'h0001) begin n_fail++; $display("FAIL abort_state: got %h want 0001", lfsr_state); end
    n_checks++; if (num !== 8'h68) begin n_fail++; $display("FAIL abort_num_kept: got %h want 68", num); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++; if (num_valid !== 1'b0 || ready !== 1'b1) begin
        n_fail++; $display("FAIL abort_quiet%0d: valid=%b ready=%b want 0/1", i, num_valid, ready);
      end
    end
    do_req16(n);
    n_checks++; if (n !== 8 || num !== 8'h68 || lfsr_state !== 16'h0168) begin
      n_fail++; $display("FAIL abort_redraw: latency=%0d num=%h state=%h want 8/68/0168", n, num, lfsr_state);
    end
    do_ack16();
  endtask

  task automatic test_zero_seed();
    @(negedge clk) begin seed_in = 16'h0000; seed_load = 1'b1; end
    n_checks++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL zero_pre_lockup: got %b want 0", lockup); end
    @(negedge clk) seed_load = 1'b0;
    n_checks++; if (lockup !== 1'b1) begin n_fail++; $display("FAIL zero_lockup: got %b want 1", lockup); end
    n_checks++; if (lfsr_state !== 16'h0001) begin n_fail++; $display("FAIL zero_state: got %h want 0001", lfsr_state); end
    @(negedge clk);
    n_checks++; if (lockup !== 1'b0 || lfsr_state !== 16'h0001) begin
      n_fail++; $display("FAIL zero_pulse_end: lockup=%b state=%h want 0/0001", lockup, lfsr_state);
    end
  endtask

  task automatic test_period4();
    int n;
    logic [15:0] seen;
    logic [3:0]  first;
    seen  = '0;
    first = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) req4 = 1'b1;
      @(negedge clk) req4 = 1'b0;
      n = 0;
      while (!valid4 && n < 10) begin
        @(negedge clk);
        n++;
      end
      n_checks++; if (n !== 1 || num4 !== seq4[i % 15] || state4 !== seq4[i % 15]) begin
        n_fail++; $display("FAIL w4_draw%0d: latency=%0d num=%h state=%h want 1/%h/%h",
                           i, n, num4, state4, seq4[i % 15], seq4[i % 15]);
      end
      if (i == 0) first = num4;
      if (i < 15) seen[num4] = 1'b1;
      @(negedge clk) ack4 = 1'b1;
      @(negedge clk) ack4 = 1'b0;
    end
    n_checks++; if (seen !== 16'hFFFE) begin n_fail++; $display("FAIL w4_distinct: got %h want fffe", seen); end
    n_checks++; if (num4 !== first) begin n_fail++; $display("FAIL w4_wrap: got %h want %h", num4, first); end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk) req4 = 1'b1;
    @(negedge clk) req4 = 1'b0;
    n_checks++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_shift: ready=%b want 0", ready4); end
    reset4 = 1'b1;
    #1;
    n_checks++; if (ready4 !== 1'b1 || valid4 !== 1'b0 || num4 !== 4'h0 || state4 !== 4'h1 || lockup4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: ready=%b valid=%b num=%h state=%h lockup=%b want 1/0/0/1/0",
                         ready4, valid4, num4, state4, lockup4);
    end
    @(negedge clk) reset4 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (valid4 !== 1'b0 || ready4 !== 1'b1 || state4 !== 4'h1) begin
      n_fail++; $display("FAIL rst_mid_lost: valid=%b ready=%b state=%h want 0/1/1", valid4, ready4, state4);
    end
  endtask

  initial begin
    reset = 1'b1; seed_load = 1'b0; seed_in = '0; req = 1'b0; num_ack = 1'b0;
    reset4 = 1'b1; seed_load4 = 1'b0; seed_in4 = '0; req4 = 1'b0; ack4 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_first_draw();
    test_back_to_back();
    test_hold();
    test_seed_abort();
    test_zero_seed();
    test_period4();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
# lfsr_rand_gen

Parametrised on-demand pseudo-random number generator built on a Galois LFSR of configurable width and tap polynomial. Each accepted request advances the LFSR a configurable number of shifts, then presents an OUT_W-bit draw under a valid/ack handshake. The block adds runtime seeding and all-zero lock-up recovery. It sits beside game logic and feeds spawn positions, enemy choices and similar consumers that need fresh decorrelated numbers on request.

## Interface
- WIDTH, 16: LFSR width, 4..32.
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits; bit i set means XOR into bit i.
- SEED, 16'h0001: reset and recovery state, WIDTH bits, non-zero.
- OUT_W, 8: draw width, 1..WIDTH; draw = state[OUT_W-1:0].
- SHIFTS, 8: LFSR shifts per draw, 1..2^CW-1, where CW = $clog2(SHIFTS+1).
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- seed_load, in, 1: load seed_in into the LFSR this cycle.
- seed_in, in, WIDTH: seed value.
- req, in, 1: draw request; accepted when req && ready.
- ready, out, 1: registered; high only in IDLE.
- num_valid, out, 1: draw available.
- num, out, OUT_W: draw value; stable while num_valid is high.
- num_ack, in, 1: consumer takes the draw when num_valid && num_ack.
- lockup, out, 1: one-cycle pulse when an all-zero state is replaced by SEED.
- lfsr_state, out, WIDTH: current LFSR register, for debug.

## Operation
- Shift rule: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: ready = 1. When req is sampled high, the counter loads SHIFTS and the FSM moves to SHIFT.
- SHIFT: exactly one shift per cycle; the counter decrements each cycle. On the cycle the counter equals 1:
  - num takes the post-shift state[OUT_W-1:0];
  - num_valid is set;
  - the FSM moves to HOLD.
- HOLD: num and num_valid are held until num_ack is sampled high. Then num_valid clears and the FSM returns to IDLE. num keeps its last value.
- The LFSR does not shift in IDLE or HOLD.
- seed_load has priority over all FSM activity, in any state:
  - state <= seed_in;
  - FSM goes to IDLE, num_valid clears, any in-flight draw is aborted;
  - num is unchanged;
  - a simultaneous req or num_ack is ignored.
- Zero recovery: if seed_in == 0 on a load, the state loads SEED instead and lockup pulses the next cycle. The LFSR is therefore never 0 outside reset.
- Reset values:
  - state = SEED;
  - FSM = IDLE, ready = 1;
  - num_valid = 0, num = 0, lockup = 0;
  - counter = 0.
- Priority order: reset, then seed_load, then FSM.

## Timing
- Request accepted at edge E0; shifts occur at edges E1..E_SHIFTS.
- num_valid rises at E_SHIFTS (SHIFTS cycles after acceptance) and carries the value from the final shift.
- ready is low from E0 until the edge after the ack.
- Minimum back-to-back draw period: SHIFTS + 2 cycles, counting one ack cycle and one IDLE cycle.
- req while ready is low is ignored. It is not queued.
- Reset mid-SHIFT or mid-HOLD: outputs take their reset values immediately (asynchronous); the draw is lost.
- Period: with a primitive TAPS, lfsr_state returns to its start value after exactly 2^WIDTH − 1 shifts.

## Structure
- Shared package holds:
  - the FSM state enum (2 bits);
  - default tap masks for widths 4, 8, 16, 32 (4'hC, 8'hB8, 16'hB400, 32'hA3000000);
  - a galois_step function.
- Natural sub-module: lfsr_galois_core (WIDTH, TAPS, SEED). Inputs: shift_en, load, load_val. Outputs: state, lockup. It contains the zero-recovery logic.
- The top level holds the FSM, the shift counter and the output registers.
- Elaboration checks: SEED != 0; 1 ≤ OUT_W ≤ WIDTH; SHIFTS ≥ 1.

## Test plan
- Defaults, release reset, one req → num_valid after 8 cycles, num = 0x68, lfsr_state = 0x0168; ack → ready returns high.
- Second draw from that state → num = 0x41, lfsr_state = 0x7C41.
- Hold num_ack low for 20 cycles during HOLD → num stays 0x68, ready stays 0, lfsr_state stays frozen.
- seed_load with seed_in = 0x0001 during SHIFT (cycle 3) → num_valid never rises, FSM returns to IDLE; a following draw yields 0x68.
- seed_load with seed_in = 0 → lockup pulses for exactly one cycle, lfsr_state = 0x0001.
- WIDTH=4, TAPS=4'hC, SHIFTS=1, OUT_W=4: 15 consecutive draws → all values distinct and non-zero; the 16th draw equals the 1st. Also assert reset during SHIFT → outputs return to reset values immediately.
